// File: rtl/pcs_rx_gearbox_if.sv
// SERDES-side word input and 66b block output bundle of pcs_rx_gearbox.
// master drives SERDES words and slip requests; slave is the gearbox.
interface pcs_rx_gearbox_if #(
  parameter int unsigned LANE_N = 4,
  parameter int unsigned HEAD_W = 2,
  parameter int unsigned DATA_W = 64
);
  logic [LANE_N-1:0]        serdes_v_i;
  logic [LANE_N*DATA_W-1:0] serdes_data_i;
  logic [LANE_N-1:0]        slip_i;
  logic [LANE_N-1:0]        valid_o;
  logic [LANE_N*HEAD_W-1:0] head_o;
  logic [LANE_N*DATA_W-1:0] data_o;

  modport master (
    output serdes_v_i, serdes_data_i, slip_i,
    input  valid_o, head_o, data_o
  );

  modport slave (
    input  serdes_v_i, serdes_data_i, slip_i,
    output valid_o, head_o, data_o
  );
endinterface

// File: rtl/pcs_rx_gearbox.sv
// Per-lane 64b->66b receive gearbox with one-bit slip for block alignment.
// Define PCS_RX_GEARBOX_SLIP_CNT_EN to add per-lane saturating applied-slip counters.
module pcs_rx_gearbox #(
  parameter int unsigned LANE_N  = 4,
  parameter int unsigned HEAD_W  = 2,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned BLOCK_W = HEAD_W + DATA_W
) (
  input  logic                clk,
  input  logic                reset,
  pcs_rx_gearbox_if.slave     gb_io
`ifdef PCS_RX_GEARBOX_SLIP_CNT_EN
  ,
  output logic [LANE_N*8-1:0] slip_cnt_o
`endif
);

  localparam int unsigned BufW = BLOCK_W + DATA_W;
  localparam int unsigned CntW = $clog2(BLOCK_W);
  localparam int unsigned NW   = CntW + 1;
  localparam logic [BufW-1:0] WordMask = BufW'({DATA_W{1'b1}});

  logic [LANE_N-1:0]        valid_w;
  logic [LANE_N*HEAD_W-1:0] head_w;
  logic [LANE_N*DATA_W-1:0] data_w;

  assign gb_io.valid_o = valid_w;
  assign gb_io.head_o  = head_w;
  assign gb_io.data_o  = data_w;

  for (genvar l = 0; l < LANE_N; l++) begin : g_lane
    logic              v_in;
    logic              slip_in;
    logic [DATA_W-1:0] word;
    logic [BufW-1:0]   buf_q, buf_d, buf_ins;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [NW-1:0]     n_fill;
    logic              slip_pend_q, slip_pend_d;
    logic              slip_apply;
    logic              valid_q, valid_d;
    logic [HEAD_W-1:0] head_q, head_d;
    logic [DATA_W-1:0] data_q, data_d;

    assign v_in       = gb_io.serdes_v_i[l];
    assign slip_in    = gb_io.slip_i[l];
    assign word       = gb_io.serdes_data_i[l*DATA_W +: DATA_W];
    assign slip_apply = slip_in | slip_pend_q;

    always_comb begin
      // Bits at or above cnt_q are always zero; masking keeps the insert exact anyway.
      buf_ins     = (buf_q & ~(WordMask << cnt_q)) | (BufW'(word) << cnt_q);
      n_fill      = NW'(cnt_q) + NW'(DATA_W);
      buf_d       = buf_q;
      cnt_d       = cnt_q;
      slip_pend_d = slip_pend_q | slip_in;
      valid_d     = 1'b0;
      head_d      = head_q;
      data_d      = data_q;
      if (v_in) begin
        slip_pend_d = 1'b0;
        if (slip_apply) begin
          buf_ins = buf_ins >> 1;
          n_fill  = n_fill - NW'(1);
        end
        if (n_fill >= NW'(BLOCK_W)) begin
          valid_d = 1'b1;
          head_d  = buf_ins[HEAD_W-1:0];
          data_d  = buf_ins[HEAD_W +: DATA_W];
          buf_d   = buf_ins >> BLOCK_W;
          cnt_d   = CntW'(n_fill - NW'(BLOCK_W));
        end else begin
          buf_d = buf_ins;
          cnt_d = CntW'(n_fill);
        end
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        buf_q       <= '0;
        cnt_q       <= '0;
        slip_pend_q <= 1'b0;
        valid_q     <= 1'b0;
        head_q      <= '0;
        data_q      <= '0;
      end else begin
        buf_q       <= buf_d;
        cnt_q       <= cnt_d;
        slip_pend_q <= slip_pend_d;
        valid_q     <= valid_d;
        head_q      <= head_d;
        data_q      <= data_d;
      end
    end

    assign valid_w[l]                 = valid_q;
    assign head_w[l*HEAD_W +: HEAD_W] = head_q;
    assign data_w[l*DATA_W +: DATA_W] = data_q;

`ifdef PCS_RX_GEARBOX_SLIP_CNT_EN
    logic [7:0] slip_cnt_q, slip_cnt_d;

    always_comb begin
      slip_cnt_d = slip_cnt_q;
      if (v_in && slip_apply && (slip_cnt_q != 8'hff)) begin
        slip_cnt_d = slip_cnt_q + 8'd1;
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        slip_cnt_q <= '0;
      end else begin
        slip_cnt_q <= slip_cnt_d;
      end
    end

    assign slip_cnt_o[l*8 +: 8] = slip_cnt_q;
`endif
  end

endmodule

// File: tb/tb_pcs_rx_gearbox.sv
// Bench for pcs_rx_gearbox: serial-stream model with block-position arithmetic plus literal pins.
module tb_pcs_rx_gearbox;
  localparam int LANE_N = 4;
  localparam int HEAD_W = 2;
  localparam int DATA_W = 64;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  pcs_rx_gearbox_if #(.LANE_N(LANE_N), .HEAD_W(HEAD_W), .DATA_W(DATA_W)) gb ();

`ifdef PCS_RX_GEARBOX_SLIP_CNT_EN
  logic [LANE_N*8-1:0] slip_cnt;
`endif

  pcs_rx_gearbox #(.LANE_N(LANE_N), .HEAD_W(HEAD_W), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .gb_io      (gb.slave)
`ifdef PCS_RX_GEARBOX_SLIP_CNT_EN
    ,
    .slip_cnt_o (slip_cnt)
`endif
  );

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;
  int off[LANE_N];
  int txp[LANE_N];

  // Transmit stream: off junk bits, then blocks of header 2'b01 (bit 0 first) + payload.
  function automatic logic [63:0] payload(input int l, input int blk);
    return {8'(l), 24'h5A5A5A, 32'(blk)};
  endfunction

  function automatic bit tx_bit(input int l, input int p);
    int q, r;
    logic [63:0] pl;
    if (p < off[l]) return bit'(((p * 7 + l) % 3) == 0);
    q = p - off[l];
    r = q % 66;
    if (r == 0) return 1'b1;
    if (r == 1) return 1'b0;
    pl = payload(l, q / 66);
    return pl[r-2];
  endfunction

  function automatic logic [65:0] stream_block(input int l, input int pos);
    logic [65:0] b;
    for (int i = 0; i < 66; i++) b[i] = tx_bit(l, pos + i);
    return b;
  endfunction

  // Model: next block starts at stream position 66*blocks + slipped bits.
  int                m_r[LANE_N];
  int                m_d[LANE_N];
  int                m_b[LANE_N];
  bit                m_pend[LANE_N];
  int                e_scnt[LANE_N];
  logic [LANE_N-1:0] e_valid;
  logic [HEAD_W-1:0] e_head[LANE_N];
  logic [DATA_W-1:0] e_data[LANE_N];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int l = 0; l < LANE_N; l++) begin
        m_r[l]    <= 0;
        m_d[l]    <= 0;
        m_b[l]    <= 0;
        m_pend[l] <= 1'b0;
        e_scnt[l] <= 0;
        e_valid[l] <= 1'b0;
        e_head[l] <= '0;
        e_data[l] <= '0;
      end
    end else begin
      for (int l = 0; l < LANE_N; l++) begin
        automatic int d = m_d[l];
        automatic int st;
        automatic logic [65:0] blk;
        if (gb.serdes_v_i[l]) begin
          if (gb.slip_i[l] || m_pend[l]) begin
            d = d + 1;
            if (e_scnt[l] < 255) e_scnt[l] <= e_scnt[l] + 1;
          end
          m_pend[l] <= 1'b0;
          m_d[l]    <= d;
          m_r[l]    <= m_r[l] + 64;
          st = 66 * m_b[l] + d;
          if (m_r[l] + 64 - st >= 66) begin
            blk = stream_block(l, st);
            e_valid[l] <= 1'b1;
            e_head[l]  <= blk[1:0];
            e_data[l]  <= blk[65:2];
            m_b[l]     <= m_b[l] + 1;
          end else begin
            e_valid[l] <= 1'b0;
          end
        end else begin
          e_valid[l] <= 1'b0;
          if (gb.slip_i[l]) m_pend[l] <= 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int l = 0; l < LANE_N; l++) begin
        n_chk++;
        if (gb.valid_o[l] !== e_valid[l] || gb.head_o[l*HEAD_W +: HEAD_W] !== e_head[l] ||
            gb.data_o[l*DATA_W +: DATA_W] !== e_data[l]) begin
          n_err++;
          $display("FAIL model lane%0d t=%0t: got v=%b h=%b d=%h, want v=%b h=%b d=%h", l, $time,
                   gb.valid_o[l], gb.head_o[l*HEAD_W +: HEAD_W], gb.data_o[l*DATA_W +: DATA_W],
                   e_valid[l], e_head[l], e_data[l]);
        end
`ifdef PCS_RX_GEARBOX_SLIP_CNT_EN
        n_chk++;
        if (slip_cnt[l*8 +: 8] !== 8'(e_scnt[l])) begin
          n_err++;
          $display("FAIL slip_cnt lane%0d: got %0d want %0d", l, slip_cnt[l*8 +: 8], e_scnt[l]);
        end
`endif
      end
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step(input logic [LANE_N-1:0] v, input logic [LANE_N-1:0] sl);
    logic [LANE_N*DATA_W-1:0] wd = '0;
    for (int l = 0; l < LANE_N; l++) begin
      if (v[l]) begin
        for (int i = 0; i < DATA_W; i++) wd[l*DATA_W + i] = tx_bit(l, txp[l] + i);
        txp[l] += DATA_W;
      end
    end
    gb.serdes_v_i    = v;
    gb.slip_i        = sl;
    gb.serdes_data_i = wd;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input int o0, input int o1, input int o2, input int o3);
    #2;
    reset = 1'b1;
    gb.serdes_v_i    = '0;
    gb.slip_i        = '0;
    gb.serdes_data_i = '0;
    off[0] = o0; off[1] = o1; off[2] = o2; off[3] = o3;
    for (int l = 0; l < LANE_N; l++) txp[l] = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // A few words with no slips; every block seen on a lane in mask must carry header 2'b01.
  task automatic chk_aligned(input string name, input logic [LANE_N-1:0] mask);
    for (int k = 0; k < 4; k++) begin
      step('1, '0);
      for (int l = 0; l < LANE_N; l++) begin
        if (mask[l] && gb.valid_o[l]) begin
          check({name, "_head"}, 128'(gb.head_o[l*HEAD_W +: HEAD_W]), 128'(2'b01));
          check({name, "_tag"}, 128'(gb.data_o[l*DATA_W + 32 +: 32]),
                128'({8'(l), 24'h5A5A5A}));
        end
      end
    end
  endtask

  int first_k;
  int pulses;

  initial begin
    gb.serdes_v_i    = '0;
    gb.slip_i        = '0;
    gb.serdes_data_i = '0;
    for (int l = 0; l < LANE_N; l++) begin
      off[l] = 0;
      txp[l] = 0;
    end
    @(negedge clk);
    do_reset(0, 0, 0, 0);
    chk_en = 1'b1;
    check("reset_valid", 128'(gb.valid_o), 128'(0));

    // 33 aligned words -> 32 blocks, first one after the 2nd word.
    first_k = -1;
    pulses  = 0;
    for (int k = 0; k < 33; k++) begin
      step('1, '0);
      if (gb.valid_o[0]) begin
        pulses++;
        if (first_k < 0) begin
          first_k = k;
          check("t1_head0", 128'(gb.head_o[1:0]), 128'(2'b01));
          check("t1_data0", 128'(gb.data_o[63:0]), 128'(64'h005A5A5A_00000000));
          check("t1_data0_l3", 128'(gb.data_o[255:192]), 128'(64'h035A5A5A_00000000));
        end
      end
    end
    check("t1_first_valid", 128'(first_k), 128'(1));
    check("t1_pulses", 128'(pulses), 128'(32));
    step('1, '0);
    check("t1_gap34", 128'(gb.valid_o), 128'(0));

    // Offset 5 on all lanes, 5 slips 8 cycles apart.
    do_reset(5, 5, 5, 5);
    for (int k = 0; k < 40; k++) step('1, (k % 8 == 0) ? 4'b1111 : 4'b0000);
    chk_aligned("t2", 4'b1111);
`ifdef PCS_RX_GEARBOX_SLIP_CNT_EN
    check("t2_slip_cnt", 128'(slip_cnt), 128'(32'h05050505));
`endif

    // 66 slips on lane 0 brings it back to the original boundary.
    do_reset(0, 0, 0, 0);
    for (int k = 0; k < 66; k++) step('1, 4'b0001);
    chk_aligned("t3", 4'b1111);
`ifdef PCS_RX_GEARBOX_SLIP_CNT_EN
    check("t3_slip_cnt", 128'(slip_cnt), 128'(32'h00000042));
`endif

    // Three-cycle gap with a slip requested on lane 0 in the middle.
    do_reset(0, 0, 0, 0);
    for (int k = 0; k < 10; k++) step('1, '0);
    step('0, '0);
    check("t4_gap0", 128'(gb.valid_o), 128'(0));
    step('0, 4'b0001);
    check("t4_gap1", 128'(gb.valid_o), 128'(0));
    step('0, '0);
    check("t4_gap2", 128'(gb.valid_o), 128'(0));
`ifdef PCS_RX_GEARBOX_SLIP_CNT_EN
    check("t4_cnt_pending", 128'(slip_cnt[7:0]), 128'(0));
    step('1, '0);
    check("t4_cnt_applied", 128'(slip_cnt[7:0]), 128'(1));
`endif
    for (int k = 0; k < 10; k++) step('1, '0);
    chk_aligned("t4", 4'b1110);

    // Async reset at cnt=30: outputs clear at once, fresh stream restarts cleanly.
    do_reset(0, 0, 0, 0);
    for (int k = 0; k < 18; k++) step('1, '0);
    #2;
    reset = 1'b1;
    #1;
    check("t5_rst_valid", 128'(gb.valid_o), 128'(0));
    check("t5_rst_head", 128'(gb.head_o), 128'(0));
    check("t5_rst_data", {gb.data_o[127:0]}, 128'(0));
    gb.serdes_v_i = '0;
    gb.slip_i     = '0;
    for (int l = 0; l < LANE_N; l++) txp[l] = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    step('1, '0);
    check("t5_word0", 128'(gb.valid_o), 128'(0));
    step('1, '0);
    check("t5_word1", 128'(gb.valid_o), 128'(4'b1111));
    check("t5_data0", 128'(gb.data_o[63:0]), 128'(64'h005A5A5A_00000000));

    // Per-lane offsets, slips only on lane 2.
    do_reset(0, 13, 7, 29);
    for (int k = 0; k < 40; k++) step('1, ((k % 4 == 0) && (k < 28)) ? 4'b0100 : 4'b0000);
    chk_aligned("t6", 4'b0101);
`ifdef PCS_RX_GEARBOX_SLIP_CNT_EN
    check("t6_slip_cnt", 128'(slip_cnt), 128'(32'h00070000));

    do_reset(0, 0, 0, 0);
    for (int k = 0; k < 260; k++) step('1, 4'b0001);
    check("t7_slip_sat", 128'(slip_cnt[7:0]), 128'(8'hff));
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
